// File: rtl/carry_bypass_adder.sv
// rtl/carry_bypass_adder.sv - registered carry-bypass adder (optional Ovf output under CBP_OVERFLOW_EN)
module carry_bypass_adder #(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                Cin,
    output logic [NUM_BITS-1:0] Sum,
`ifdef CBP_OVERFLOW_EN
    output logic                Ovf,
`endif
    output logic                Cout
);

    localparam int BW = (NUM_STAGES >= 1) ? NUM_BITS / NUM_STAGES : 1;

    // Block width must divide the operand width, or the block chain would leave bits uncovered.
    if (NUM_STAGES < 1 || (NUM_BITS % NUM_STAGES) != 0) begin : g_param_check
        $error("carry_bypass_adder: NUM_BITS must be a multiple of NUM_STAGES and NUM_STAGES >= 1");
    end

    logic [NUM_BITS-1:0] g;
    logic [NUM_BITS-1:0] p;
    logic [NUM_BITS-1:0] sum_next;
    logic                cout_next;

    assign g = A & B;
    assign p = A ^ B;

    // Ripple inside each block; when a block fully propagates, its carry-in bypasses straight to the next block.
    always_comb begin
        logic carry;
        logic blk_in;
        logic rc;
        logic blk_prop;
        int   idx;
        sum_next = '0;
        carry    = Cin;
        blk_in   = 1'b0;
        rc       = 1'b0;
        blk_prop = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            blk_in   = carry;
            rc       = carry;
            blk_prop = 1'b1;
            for (int i = 0; i < BW; i++) begin
                idx           = k * BW + i;
                sum_next[idx] = p[idx] ^ rc;
                rc            = g[idx] | (p[idx] & rc);
                blk_prop      = blk_prop & p[idx];
            end
            carry = blk_prop ? blk_in : rc;
        end
        cout_next = carry;
    end

`ifdef CBP_OVERFLOW_EN
    logic ovf_next;
    assign ovf_next = (A[NUM_BITS-1] == B[NUM_BITS-1]) && (sum_next[NUM_BITS-1] != A[NUM_BITS-1]);

    // Signed overflow: like-signed operands produced a result of the opposite sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ovf <= 1'b0;
        end else begin
            Ovf <= ovf_next;
        end
    end
`endif

    // Output registers capture the combinational sum every cycle; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_next;
            Cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_carry_bypass_adder.sv
// tb/tb_carry_bypass_adder.sv - directed self-checking bench for carry_bypass_adder
module tb_carry_bypass_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
`ifdef CBP_OVERFLOW_EN
    logic        ovf;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    carry_bypass_adder #(.NUM_BITS(32), .NUM_STAGES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .Sum  (sum),
`ifdef CBP_OVERFLOW_EN
        .Ovf  (ovf),
`endif
        .Cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_and_check(input vec_t v);
        @(negedge clk);
        a   = v.a;
        b   = v.b;
        cin = v.cin;
        @(posedge clk);
        #1;
        check({v.tag, ".sum"}, 64'(sum), 64'(v.sum));
        check({v.tag, ".cout"}, 64'(cout), 64'(v.cout));
`ifdef CBP_OVERFLOW_EN
        check({v.tag, ".ovf"}, 64'(ovf), 64'(v.ovf));
`endif
    endtask

    initial begin
        vecs.push_back('{"add_10_20",      32'd10,         32'd20,         1'b0, 32'd30,         1'b0, 1'b0});
        vecs.push_back('{"add_10_20_c",    32'd10,         32'd20,         1'b1, 32'd31,         1'b0, 1'b0});
        vecs.push_back('{"add_15_45",      32'd15,         32'd45,         1'b0, 32'd60,         1'b0, 1'b0});
        vecs.push_back('{"neg10_neg20",    32'hFFFF_FFF6,  32'hFFFF_FFEC,  1'b0, 32'hFFFF_FFE2,  1'b1, 1'b0});
        vecs.push_back('{"neg10_neg20_c",  32'hFFFF_FFF6,  32'hFFFF_FFEC,  1'b1, 32'hFFFF_FFE3,  1'b1, 1'b0});
        vecs.push_back('{"mixed_sign_c",   32'h8000_0001,  32'h7FFF_FFFF,  1'b1, 32'd1,          1'b1, 1'b0});
        vecs.push_back('{"cancel",         32'd14958,      32'hFFFF_C592,  1'b0, 32'd0,          1'b1, 1'b0});
        vecs.push_back('{"cancel_c",       32'd14958,      32'hFFFF_C592,  1'b1, 32'd1,          1'b1, 1'b0});
        vecs.push_back('{"full_bypass",    32'hFFFF_FFFF,  32'd0,          1'b1, 32'd0,          1'b1, 1'b0});
        vecs.push_back('{"pos_ovf",        32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1});
        vecs.push_back('{"neg_ovf",        32'h8000_0000,  32'h8000_0000,  1'b0, 32'd0,          1'b1, 1'b1});
        vecs.push_back('{"pattern",        32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 32'hACF1_3568,  1'b0, 1'b0});

        rst_n = 1'b0;
        a     = 32'h1111_1111;
        b     = 32'h2222_2222;
        cin   = 1'b1;
        #2;
        check("reset.sum", 64'(sum), 64'd0);
        check("reset.cout", 64'(cout), 64'd0);
        @(posedge clk);
        #1;
        check("reset_hold.sum", 64'(sum), 64'd0);
        check("reset_hold.cout", 64'(cout), 64'd0);
`ifdef CBP_OVERFLOW_EN
        check("reset_hold.ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply_and_check(vecs[i]);

        // Outputs are nonzero here (pattern vector); drop reset away from any edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset.sum", 64'(sum), 64'd0);
        check("mid_reset.cout", 64'(cout), 64'd0);
        a   = 32'hFFFF_FFFF;
        b   = 32'hFFFF_FFFF;
        cin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset.sum", 64'(sum), 64'hFFFF_FFFF);
        check("post_reset.cout", 64'(cout), 64'd1);
`ifdef CBP_OVERFLOW_EN
        check("post_reset.ovf", 64'(ovf), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/carry_bypass_adder.md
# carry_bypass_adder

Parameterized carry-bypass (carry-skip) adder with registered outputs. It splits the NUM_BITS operands into NUM_STAGES equal ripple-carry blocks, each with a propagate-driven bypass mux on its carry out. It sits in the datapath wherever a one-cycle-latency adder with carry-in and carry-out is needed. Operands are two's-complement or unsigned; the bit-level result is identical for both.

## Interface

Parameters:

- NUM_BITS, 32, operand and sum width.
- NUM_STAGES, 4, number of bypass blocks. NUM_BITS must be an exact multiple of NUM_STAGES; block width is BW = NUM_BITS/NUM_STAGES.

Ports:

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- A  input  NUM_BITS  operand A.
- B  input  NUM_BITS  operand B.
- Cin  input  1  carry into bit 0.
- Sum  output  NUM_BITS  registered (A + B + Cin) mod 2^NUM_BITS.
- Cout  output  1  registered carry out of bit NUM_BITS-1.
- Ovf  output  1  registered signed overflow. Present only when CBP_OVERFLOW_EN is defined.

## Operation

- Combinational core, with A, B and Cin not registered at the input:
  - Per-bit generate g[i] = A[i] & B[i].
  - Per-bit propagate p[i] = A[i] ^ B[i].
  - Block k covers bits [k*BW +: BW] and receives carry c[k]. c[0] = Cin.
  - Within a block, ripple carry: c_bit[i+1] = g[i] | (p[i] & c_bit[i]); sum bit = p[i] ^ c_bit[i].
  - Block propagate P[k] = AND of p[] over the block.
  - Block carry out c[k+1] = P[k] ? c[k] : ripple carry out of the block's MSB.
- The result must equal the full-width arithmetic sum {Cout, Sum} = A + B + Cin (NUM_BITS+1 bits) for every input combination.
- Cout is the raw unsigned carry. It is not a signed-overflow indicator.
- Sum is a plain bit vector, with no sign extension or saturation.
- Parameter check: an elaboration-time error is raised if NUM_BITS % NUM_STAGES != 0 or NUM_STAGES < 1.

## Timing

- Output registers capture the combinational result on every rising clk edge. There is no enable and no handshake.
- Latency is 1 cycle: inputs applied before edge N appear on Sum/Cout after edge N. Throughput is one addition per cycle.
- While rst_n = 0: Sum = 0, Cout = 0 and Ovf = 0, all immediately and asynchronously, independent of clk.
- Reset deassertion: the first rising edge with rst_n = 1 loads the current inputs.
- Reset asserted mid-stream: registers clear at once. The addition captured at the previous edge is lost, and there is no recovery.
- Combinational path from inputs to registers: worst case is about 2*BW bit delays plus NUM_STAGES-2 bypass-mux delays. It must meet one clk period at the target frequency.

## Configuration

- CBP_OVERFLOW_EN defined:
  - Ovf port exists.
  - Ovf is registered as (A[MSB] == B[MSB]) && (Sum_next[MSB] != A[MSB]), where Sum_next is the combinational sum.
  - Ovf resets to 0.
- CBP_OVERFLOW_EN undefined: the Ovf port and its logic are absent. All other behaviour is unchanged.

## Test plan

Defaults apply (NUM_BITS = 32, NUM_STAGES = 4). Check each result one cycle after the inputs are applied, out of reset.

- A=10, B=20, Cin=0 -> Sum=30, Cout=0. With Cin=1 -> Sum=31, Cout=0. A=15, B=45, Cin=0 -> Sum=60, Cout=0.
- A=-10, B=-20, Cin=0 -> Sum=0xFFFFFFE2 (-30), Cout=1. With Cin=1 -> Sum=0xFFFFFFE3 (-29), Cout=1.
- A=0x80000001, B=0x7FFFFFFF, Cin=1 -> Sum=1, Cout=1, Ovf=0.
- A=14958, B=-14958, Cin=0 -> Sum=0, Cout=1. With Cin=1 -> Sum=1, Cout=1. This exercises the full bypass chain.
- Bypass corners:
  - A=0xFFFFFFFF, B=0, Cin=1 -> Sum=0, Cout=1.
  - A=0x7FFFFFFF, B=1, Cin=0 -> Sum=0x80000000, Cout=0, Ovf=1.
- Assert rst_n low mid-sequence -> Sum=0, Cout=0 immediately without a clock edge. After release, the next edge loads the current inputs.
